// File: rtl/fetch_ctrl_pkg.sv
// Shared types and encodings for the instruction-fetch sequencing controller.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HALTED   = 3'd4
    } fetch_state_e;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    // Any non-sequential PC source is a taken branch or jump.
    function automatic logic is_redirect(input logic [1:0] pcsrc);
        return pcsrc != PCSRC_PLUS4;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Control/status bundle between the pipeline and the fetch sequencing controller.
interface fetch_seq_ctrl_if #(parameter int CNT_WIDTH = 32);
    logic                 trigger;
    logic [1:0]           pcsrc_e;
    logic                 load_use_hazard;
    logic                 imem_ready;
    logic                 halt_instr;
    logic                 pc_en;
    logic                 stall_f;
    logic                 stall_d;
    logic                 flush_d;
    logic                 flush_e;
    logic                 imem_req;
    logic                 busy;
    logic [2:0]           state_o;
    logic [CNT_WIDTH-1:0] fetch_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;

    modport master (
        output trigger, pcsrc_e, load_use_hazard, imem_ready, halt_instr,
        input  pc_en, stall_f, stall_d, flush_d, flush_e, imem_req, busy,
               state_o, fetch_cnt, stall_cnt
    );

    modport slave (
        input  trigger, pcsrc_e, load_use_hazard, imem_ready, halt_instr,
        output pc_en, stall_f, stall_d, flush_d, flush_e, imem_req, busy,
               state_o, fetch_cnt, stall_cnt
    );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector: registered previous value, asynchronous active-high reset.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic prev_q, prev_d;

    always_comb prev_d = d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= prev_d;
    end

    assign rise = d & ~prev_q;
endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencing controller: PC enable, stall/flush and fetch request generation.
// Optional saturating performance counters enabled by macro FETCH_PERF_COUNT_EN.
import fetch_ctrl_pkg::*;

module fetch_seq_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_seq_ctrl_if.slave bus
);
    fetch_state_e state_q, state_d;
    logic trig_rise;
    logic redirect;
    logic pc_en, stall_f, stall_d, flush_d, flush_e, imem_req, busy;

    edge_detect u_trig_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.trigger),
        .rise (trig_rise)
    );

    assign redirect = is_redirect(bus.pcsrc_e);

    always_comb begin
        state_d  = state_q;
        pc_en    = 1'b0;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        imem_req = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (trig_rise) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (redirect) begin
                    pc_en   = 1'b1;
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    state_d = ST_REDIRECT;
                end else if (!bus.trigger) begin
                    state_d = ST_IDLE;
                end else if (bus.halt_instr) begin
                    flush_d = 1'b1;
                    state_d = ST_HALTED;
                end else if (bus.load_use_hazard) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end else if (!bus.imem_ready) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    state_d = ST_WAIT_MEM;
                end else begin
                    pc_en = 1'b1;
                end
            end
            ST_WAIT_MEM: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                // A redirect abandons the outstanding request even without imem_ready.
                if (redirect) begin
                    pc_en   = 1'b1;
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    state_d = ST_REDIRECT;
                end else if (!bus.trigger) begin
                    state_d = ST_IDLE;
                end else if (bus.imem_ready) begin
                    state_d = ST_FETCH;
                    if (bus.load_use_hazard) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = bus.load_use_hazard;
                end
            end
            ST_REDIRECT: begin
                busy    = 1'b1;
                flush_d = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    assign bus.pc_en    = pc_en;
    assign bus.stall_f  = stall_f;
    assign bus.stall_d  = stall_d;
    assign bus.flush_d  = flush_d;
    assign bus.flush_e  = flush_e;
    assign bus.imem_req = imem_req;
    assign bus.busy     = busy;
    assign bus.state_o  = state_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pc_en   && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 1'b1;
        if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.fetch_cnt = {CNT_WIDTH{1'b0}};
    assign bus.stall_cnt = {CNT_WIDTH{1'b0}};
`endif
endmodule
